// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift-register slice: FSM state codes and the
// on-chip register length used by both the transmit and the readback blocks.
package shiftreg_pkg;

    localparam int SR_WIDTH = 170;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/sr_clk_gen.sv
// Phase counter for the serial shift clock: DIV cycles low, then DIV cycles high
// per bit; flags the last high cycle. Held cleared while enable is low.
module sr_clk_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic phase,
    output logic bit_end
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LOW_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(2 * DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // Divider count and registered clk_sr level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end else if (!enable) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end else if (cnt_r == HIGH_LAST) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == LOW_LAST) begin
                phase_r <= 1'b1;
            end
        end
    end

    assign phase   = phase_r;
    assign bit_end = enable & (cnt_r == HIGH_LAST);

endmodule

// File: rtl/shiftreg_tx.sv
// Serial transmitter loading one WIDTH-bit word into the test chip's shift register.
// Define SHIFTREG_TX_LSB_FIRST_EN to send sh[0] first (default is MSB first).
module shiftreg_tx
    import shiftreg_pkg::*;
#(
    parameter int WIDTH    = SR_WIDTH,
    parameter int DIV      = 2,
    parameter int LOAD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             din_sr,
    output logic             clk_sr,
    output logic             load_sr,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int LCW = $clog2(LOAD_CYC + 1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] sh_r;
    logic [BCW-1:0]   bit_cnt_r;
    logic [LCW-1:0]   load_cnt_r;
    logic             din_sr_r;
    logic             load_sr_r;
    logic             busy_r;
    logic             done_r;
    logic             armed_r;
    logic             shift_en_s;
    logic             phase_s;
    logic             bit_end_s;
    logic [WIDTH-1:0] sh_next_s;

    function automatic logic tx_bit(input logic [WIDTH-1:0] w);
`ifdef SHIFTREG_TX_LSB_FIRST_EN
        return w[0];
`else
        return w[WIDTH-1];
`endif
    endfunction

    // Shadow word after one shift, with zero fill on the far end
    always_comb begin
`ifdef SHIFTREG_TX_LSB_FIRST_EN
        sh_next_s = {1'b0, sh_r[WIDTH-1:1]};
`else
        sh_next_s = {sh_r[WIDTH-2:0], 1'b0};
`endif
    end

    assign shift_en_s = (state_r == SHIFT);

    sr_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .enable  (shift_en_s),
        .phase   (phase_s),
        .bit_end (bit_end_s)
    );

    // Transfer FSM; armed_r blocks a start coinciding with reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            sh_r       <= {WIDTH{1'b0}};
            bit_cnt_r  <= {BCW{1'b0}};
            load_cnt_r <= {LCW{1'b0}};
            din_sr_r   <= 1'b0;
            load_sr_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && armed_r) begin
                        sh_r      <= din;
                        bit_cnt_r <= BCW'(WIDTH);
                        din_sr_r  <= tx_bit(din);
                        busy_r    <= 1'b1;
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_end_s) begin
                        sh_r      <= sh_next_s;
                        bit_cnt_r <= bit_cnt_r - BCW'(1);
                        if (bit_cnt_r == BCW'(1)) begin
                            din_sr_r   <= 1'b0;
                            load_sr_r  <= 1'b1;
                            load_cnt_r <= {LCW{1'b0}};
                            state_r    <= LOAD;
                        end else begin
                            din_sr_r <= tx_bit(sh_next_s);
                        end
                    end
                end
                LOAD: begin
                    if (load_cnt_r == LCW'(LOAD_CYC - 1)) begin
                        load_sr_r <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        load_cnt_r <= load_cnt_r + LCW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    din_sr_r  <= 1'b0;
                    load_sr_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign din_sr  = din_sr_r;
    assign clk_sr  = phase_s;
    assign load_sr = load_sr_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_shiftreg_tx.sv
// Bench for shiftreg_tx: an 8-bit/DIV=1 instance and a 170-bit/DIV=2 instance,
// each compared every cycle against a timeline model of the transfer.
module tb_shiftreg_tx;
    import shiftreg_pkg::*;

    localparam int WA = 8;
    localparam int DA = 1;
    localparam int WB = SR_WIDTH;
    localparam int DB = 2;
    localparam int LC = 2;
    localparam int TOT_A = 2 * DA * WA + LC + 1;
    localparam int TOT_B = 2 * DB * WB + LC + 1;
    localparam int VW = 170;
    typedef logic [VW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_a = 1'b0;
    logic          start_b = 1'b0;
    logic [WA-1:0] din_a = 8'h00;
    logic [WB-1:0] din_b = {WB{1'b0}};
    logic din_sr_a, clk_sr_a, load_sr_a, busy_a, done_a;
    logic din_sr_b, clk_sr_b, load_sr_b, busy_b, done_b;
    logic [4:0] out_a, out_b;

    int n_checks = 0;
    int n_errors = 0;

    int   ta = 0;
    int   tb = 0;
    vec_t wa = '0;
    vec_t wb = '0;
    bit   armed = 1'b0;

    shiftreg_tx #(.WIDTH(WA), .DIV(DA), .LOAD_CYC(LC)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .din(din_a),
        .din_sr(din_sr_a), .clk_sr(clk_sr_a), .load_sr(load_sr_a), .busy(busy_a), .done(done_a)
    );

    shiftreg_tx #(.WIDTH(WB), .DIV(DB), .LOAD_CYC(LC)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .din(din_b),
        .din_sr(din_sr_b), .clk_sr(clk_sr_b), .load_sr(load_sr_b), .busy(busy_b), .done(done_b)
    );

    assign out_a = {din_sr_a, clk_sr_a, load_sr_a, busy_a, done_a};
    assign out_b = {din_sr_b, clk_sr_b, load_sr_b, busy_b, done_b};

    initial forever #5 clk = ~clk;

    // Expected {din_sr, clk_sr, load_sr, busy, done} in cycle t after an accepted start
    function automatic logic [4:0] exp_out(input int t, input vec_t w, input int W, input int D, input int L);
        int k, ph, idx;
        if (t < 1) return 5'b00000;
        if (t <= 2 * D * W) begin
            k  = (t - 1) / (2 * D);
            ph = (t - 1) % (2 * D);
`ifdef SHIFTREG_TX_LSB_FIRST_EN
            idx = k;
`else
            idx = W - 1 - k;
`endif
            return {w[idx], (ph >= D), 1'b0, 1'b1, 1'b0};
        end
        if (t <= 2 * D * W + L) return 5'b00110;
        if (t == 2 * D * W + L + 1) return 5'b00001;
        return 5'b00000;
    endfunction

    // Model: position within the transfer timeline, 0 when idle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ta <= 0;
            tb <= 0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (ta != 0) ta <= (ta == TOT_A) ? 0 : ta + 1;
            else if (start_a && armed) begin ta <= 1; wa <= vec_t'(din_a); end
            if (tb != 0) tb <= (tb == TOT_B) ? 0 : tb + 1;
            else if (start_b && armed) begin tb <= 1; wb <= vec_t'(din_b); end
        end
    end

    task automatic chk(input string name, input vec_t act, input vec_t req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("cycle_a", vec_t'(out_a), vec_t'(exp_out(ta, wa, WA, DA, LC)));
            chk("cycle_b", vec_t'(out_b), vec_t'(exp_out(tb, wb, WB, DB, LC)));
        end
    endtask

    task automatic drive(input bit b, input logic s, input vec_t w);
        if (b) begin start_b = s; din_b = w[WB-1:0]; end
        else begin start_a = s; din_a = w[WA-1:0]; end
    endtask

    // One transfer, observed from the chip's side: bits captured on clk_sr rising edges
    task automatic xfer(input bit b, input vec_t w, input int restart_cyc, input vec_t w2,
                        input int abort_bit, output vec_t cap, output int busy_n, output int done_at,
                        output int dones, output int loads, output int edges, output int first_bit);
        int W;
        logic [4:0] o;
        logic prev_clk;
        W = b ? WB : WA;
        cap = '0; busy_n = 0; done_at = -1; dones = 0; loads = 0; edges = 0; first_bit = -1;
        prev_clk = 1'b0;
        @(negedge clk);
        drive(b, 1'b1, w);
        for (int n = 1; n <= (b ? TOT_B : TOT_A) + 4; n++) begin
            @(negedge clk);
            o = b ? out_b : out_a;
            if (o[1]) busy_n++;
            if (o[0]) begin dones++; if (done_at < 0) done_at = n; end
            if (o[2]) loads++;
            if (o[3] && !prev_clk) begin
                if (edges == 0) first_bit = int'(o[4]);
                if (edges < W) begin
`ifdef SHIFTREG_TX_LSB_FIRST_EN
                    cap[edges] = o[4];
`else
                    cap[W-1-edges] = o[4];
`endif
                end
                edges++;
            end
            prev_clk = o[3];
            if (n == 1) drive(b, 1'b0, ~w);
            else if (restart_cyc > 0 && n == restart_cyc) drive(b, 1'b1, w2);
            else if (restart_cyc > 0 && n == restart_cyc + 1) drive(b, 1'b0, w2);
            if (abort_bit > 0 && edges == abort_bit) begin
                #1 rst = 1'b0;
                #1 chk("abort_outputs_zero", vec_t'(b ? out_b : out_a), '0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t cap, alt, rw;
        int busy_n, done_at, dones, loads, edges, first_bit;

        fork compare_loop(); join_none

        for (int i = 0; i < VW; i++) alt[i] = (i % 2 == 1);

        chk("model_first_cycle", vec_t'(exp_out(1, vec_t'(8'hA5), WA, DA, LC)), vec_t'(5'b10010));
        chk("model_load_cycle", vec_t'(exp_out(17, vec_t'(8'hA5), WA, DA, LC)), vec_t'(5'b00110));
        chk("model_done_cycle", vec_t'(exp_out(19, vec_t'(8'hA5), WA, DA, LC)), vec_t'(5'b00001));

        // Reset held with start asserted
        start_a = 1'b1; start_b = 1'b1; din_a = 8'hFF; din_b = ~din_b;
        repeat (4) begin
            @(negedge clk);
            chk("reset_outputs_a", vec_t'(out_a), '0);
            chk("reset_outputs_b", vec_t'(out_b), '0);
        end
        rst = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_start_at_release_a", vec_t'(busy_a), '0);
            chk("no_start_at_release_b", vec_t'(busy_b), '0);
        end

        xfer(1'b0, vec_t'(8'hA5), 0, '0, 0, cap, busy_n, done_at, dones, loads, edges, first_bit);
        chk("a5_word", cap, vec_t'(8'hA5));
        chk("a5_first_bit", vec_t'(first_bit), vec_t'(1));
        chk("a5_busy_len", vec_t'(busy_n), vec_t'(18));
        chk("a5_done_cycle", vec_t'(done_at), vec_t'(19));
        chk("a5_load_len", vec_t'(loads), vec_t'(2));
        chk("a5_edges", vec_t'(edges), vec_t'(8));

        xfer(1'b1, alt, 0, '0, 0, cap, busy_n, done_at, dones, loads, edges, first_bit);
        chk("full_word", cap, alt);
        chk("full_edges", vec_t'(edges), vec_t'(170));
        chk("full_busy_len", vec_t'(busy_n), vec_t'(682));
        chk("full_done_cycle", vec_t'(done_at), vec_t'(683));

        xfer(1'b0, vec_t'(8'h3C), 10, vec_t'(8'hC3), 0, cap, busy_n, done_at, dones, loads, edges, first_bit);
        chk("busy_start_word", cap, vec_t'(8'h3C));
        chk("busy_start_dones", vec_t'(dones), vec_t'(1));

        rw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        xfer(1'b1, rw, 0, '0, 50, cap, busy_n, done_at, dones, loads, edges, first_bit);
        chk("abort_no_load", vec_t'(loads), '0);
        chk("abort_no_done", vec_t'(dones), '0);
        rw = ~alt;
        xfer(1'b1, rw, 0, '0, 0, cap, busy_n, done_at, dones, loads, edges, first_bit);
        chk("after_abort_word", cap, rw);
        chk("after_abort_done_cycle", vec_t'(done_at), vec_t'(683));

        xfer(1'b0, vec_t'(8'h01), 0, '0, 0, cap, busy_n, done_at, dones, loads, edges, first_bit);
`ifdef SHIFTREG_TX_LSB_FIRST_EN
        chk("h01_first_bit", vec_t'(first_bit), vec_t'(1));
`else
        chk("h01_first_bit", vec_t'(first_bit), vec_t'(0));
`endif
        chk("h01_word", cap, vec_t'(8'h01));
        chk("h01_done_cycle", vec_t'(done_at), vec_t'(19));

        // Random starts, including starts while busy and din changes mid-transfer
        repeat (2000) begin
            @(negedge clk);
            start_a = ($urandom_range(0, 15) == 0);
            din_a   = 8'($urandom);
            start_b = ($urandom_range(0, 255) == 0);
            din_b   = WB'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end
        start_a = 1'b0; start_b = 1'b0;
        repeat (TOT_B + 5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
